// File: rtl/multi_arbiter.sv
// multi_arbiter: round-robin sharing of one pipelined multiplier among NUM_REQ requesters,
// with a tag pipeline tracking ownership and a credit-protected show-ahead result FIFO.
module multi_arbiter #(
   parameter int DATA_WIDTH  = 512,
   parameter int NUM_REQ     = 4,
   parameter int MUL_LATENCY = 4,
   parameter int FIFO_DEPTH  = 8
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [NUM_REQ-1:0]              req_valid,
   output logic [NUM_REQ-1:0]              req_ready,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_dat1,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_dat2,
   output logic [DATA_WIDTH-1:0]           mul_dat1,
   output logic [DATA_WIDTH-1:0]           mul_dat2,
   input  logic [2*DATA_WIDTH-1:0]         mul_product,
   output logic                            rsp_valid,
   input  logic                            rsp_ready,
   output logic [$clog2(NUM_REQ)-1:0]      rsp_id,
   output logic [2*DATA_WIDTH-1:0]         rsp_product,
   output logic                            idle
);
   localparam int IW = $clog2(NUM_REQ);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(FIFO_DEPTH+1);
   localparam int EW = IW + 2*DATA_WIDTH;

   logic [IW-1:0] ptr, gid, cand;
   logic          found, accept, pop, wr, empty, has_credit;
   logic [CW-1:0] cnt;
   logic [AW:0]   wp, rp;
   logic [MUL_LATENCY:0] tv;
   logic [IW-1:0] tid [MUL_LATENCY+1];
   logic [EW-1:0] mem [FIFO_DEPTH];

   always_comb begin
      found = 1'b0;
      gid   = '0;
      cand  = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = IW'((32'(ptr) + 32'(k)) % NUM_REQ);
         if (!found && req_valid[cand]) begin
            found = 1'b1;
            gid   = cand;
         end
      end
   end

   assign has_credit = cnt < CW'(FIFO_DEPTH);
   assign accept     = found && has_credit;
   assign req_ready  = accept ? NUM_REQ'(1) << gid : '0;
   assign empty      = wp == rp;
   assign rsp_valid  = !empty;
   assign pop        = rsp_valid && rsp_ready;
   assign wr         = tv[MUL_LATENCY];
   assign idle       = cnt == '0;
   assign {rsp_id, rsp_product} = empty ? '0 : mem[rp[AW-1:0]];

   // Entry 0 travels with the operand register, so the last entry lines up with mul_product.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr      <= '0;
         mul_dat1 <= '0;
         mul_dat2 <= '0;
         tv       <= '0;
         for (int s = 0; s <= MUL_LATENCY; s++) tid[s] <= '0;
      end else begin
         tv     <= {tv[MUL_LATENCY-1:0], accept};
         tid[0] <= gid;
         for (int s = 1; s <= MUL_LATENCY; s++) tid[s] <= tid[s-1];
         if (accept) begin
            ptr      <= (32'(gid) == NUM_REQ-1) ? '0 : gid + 1'b1;
            mul_dat1 <= req_dat1[gid*DATA_WIDTH +: DATA_WIDTH];
            mul_dat2 <= req_dat2[gid*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wp  <= '0;
         rp  <= '0;
         cnt <= '0;
      end else begin
         wp  <= wr ? wp + 1'b1 : wp;
         rp  <= pop ? rp + 1'b1 : rp;
         cnt <= (accept && !pop) ? cnt + 1'b1 : (pop && !accept) ? cnt - 1'b1 : cnt;
      end
   end

   always_ff @(posedge clk) if (wr) mem[wp[AW-1:0]] <= {tid[MUL_LATENCY], mul_product};
endmodule

// File: tb/tb_multi_arbiter.sv
// tb_multi_arbiter: random and directed traffic against a queue-based model of the arbiter,
// with a behavioural fixed-latency multiplier in front of mul_product.
module tb_multi_arbiter;
   localparam int DW = 512;
   localparam int N  = 4;
   localparam int L  = 4;
   localparam int D  = 8;

   typedef struct {
      int             id;
      logic [2*DW-1:0] prod;
      int             due;
   } ent_t;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [N-1:0]      req_valid = '0;
   logic [N-1:0]      req_ready;
   logic [N*DW-1:0]   req_dat1 = '0;
   logic [N*DW-1:0]   req_dat2 = '0;
   logic [DW-1:0]     mul_dat1, mul_dat2;
   logic [2*DW-1:0]   mul_product;
   logic              rsp_valid;
   logic              rsp_ready = 1'b0;
   logic [1:0]        rsp_id;
   logic [2*DW-1:0]   rsp_product;
   logic              idle;

   logic [2*DW-1:0] pipe [L];
   logic [DW-1:0]   a [N];
   logic [DW-1:0]   b [N];
   logic [N-1:0]    pend = '0;
   ent_t            q[$];
   int              ptr = 0;
   int              edges = 0;
   int              vectors = 0;
   int              errs = 0;

   multi_arbiter dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_dat1(req_dat1), .req_dat2(req_dat2), .mul_dat1(mul_dat1), .mul_dat2(mul_dat2),
      .mul_product(mul_product), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_id(rsp_id), .rsp_product(rsp_product), .idle(idle)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      pipe[0] <= {{DW{1'b0}}, mul_dat1} * {{DW{1'b0}}, mul_dat2};
      for (int k = 1; k < L; k++) pipe[k] <= pipe[k-1];
   end
   assign mul_product = pipe[L-1];

   task automatic check(input string tag, input logic [2*DW-1:0] got, input logic [2*DW-1:0] exp);
      vectors++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s @edge %0d: got %0h expected %0h (low 192 bits)", tag, edges, got[191:0], exp[191:0]);
      end
   endtask

   function automatic logic [DW-1:0] rnd();
      logic [DW-1:0] r;
      for (int w = 0; w < DW/32; w++) r[w*32 +: 32] = $urandom;
      return ($urandom_range(3) == 0) ? DW'($urandom_range(1000)) : r;
   endfunction

   task automatic cycle(input logic [N-1:0] mask, input int new_pct, input int rdy_pct, input bit ones);
      int g;
      bit acc, vexp, pop;
      logic [2*DW-1:0] prod;
      @(negedge clk);
      for (int i = 0; i < N; i++)
         if (mask[i] && !pend[i] && $urandom_range(99) < new_pct) begin
            pend[i] = 1'b1;
            a[i] = ones ? '1 : rnd();
            b[i] = ones ? '1 : rnd();
         end
      for (int i = 0; i < N; i++) begin
         req_dat1[i*DW +: DW] = a[i];
         req_dat2[i*DW +: DW] = b[i];
      end
      req_valid = pend;
      rsp_ready = $urandom_range(99) < rdy_pct;
      #1;
      g = -1;
      for (int k = 0; k < N; k++) if (g < 0 && pend[(ptr+k)%N]) g = (ptr+k)%N;
      acc = g >= 0 && q.size() < D;
      check("req_ready", req_ready, acc ? (4'b1 << g) : 4'b0);
      vexp = q.size() > 0 && q[0].due <= edges;
      check("rsp_valid", rsp_valid, vexp);
      check("idle", idle, q.size() == 0);
      if (vexp) begin
         check("rsp_id", rsp_id, q[0].id);
         check("rsp_product", rsp_product, q[0].prod);
      end
      pop = vexp && rsp_ready;
      if (pop) void'(q.pop_front());
      if (acc) begin
         prod = {{DW{1'b0}}, a[g]} * {{DW{1'b0}}, b[g]};
         q.push_back('{g, prod, edges + 1 + L + 1});
         ptr = (g + 1) % N;
         pend[g] = 1'b0;
      end
      @(posedge clk);
      edges++;
   endtask

   task automatic do_reset();
      @(negedge clk);
      pend = '0;
      req_valid = '0;
      rsp_ready = 1'b0;
      rst = 1'b1;
      #1;
      check("rst rsp_valid", rsp_valid, 1'b0);
      check("rst rsp_id", rsp_id, 2'd0);
      check("rst rsp_product", rsp_product, '0);
      check("rst idle", idle, 1'b1);
      check("rst mul_dat1", mul_dat1, '0);
      check("rst mul_dat2", mul_dat2, '0);
      check("rst req_ready", req_ready, 4'b0);
      q.delete();
      ptr = 0;
      repeat (2) begin
         @(posedge clk);
         edges++;
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < N; i++) begin
         a[i] = '0;
         b[i] = '0;
      end
      do_reset();
      // single op from requester 2: 3*5
      pend[2] = 1'b1;
      a[2] = DW'(3);
      b[2] = DW'(5);
      cycle('0, 0, 100, 0);
      repeat (10) cycle('0, 0, 100, 0);
      check("single product seen", {{(2*DW-1){1'b0}}, idle}, 1);
      // all requesters streaming, full drain rate
      repeat (24) cycle(4'hf, 100, 100, 0);
      repeat (10) cycle('0, 0, 100, 0);
      // requester 0 streaming into a stalled consumer, then a single pop
      repeat (16) cycle(4'h1, 100, 0, 0);
      cycle(4'h1, 100, 100, 0);
      repeat (3) cycle(4'h1, 100, 0, 0);
      repeat (20) cycle(4'h1, 100, 100, 0);
      repeat (12) cycle('0, 0, 100, 0);
      // all-ones operands
      cycle(4'h2, 100, 100, 1);
      repeat (10) cycle('0, 0, 100, 0);
      // reset with work in flight and buffered
      repeat (5) cycle(4'h1, 100, 0, 0);
      repeat (2) cycle('0, 0, 0, 0);
      do_reset();
      repeat (8) cycle('0, 0, 100, 0);
      cycle(4'h8, 100, 100, 0);
      repeat (10) cycle('0, 0, 100, 0);
      // random traffic with random backpressure
      repeat (600) cycle(4'hf, 40, 60, 0);
      repeat (30) cycle('0, 0, 100, 0);
      check("final idle", idle, 1'b1);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end
endmodule
